// File: rtl/led_fade_driver.sv
// led_fade_driver: per-channel LED fader placed between the red-LED PIO port
// and the LEDR pins. Each channel ramps its brightness level towards full-on
// or off at a fixed rate and drives its pin with PWM at that level.
//
// Optional build macro: LED_FADE_GAMMA_EN
//   defined   -> PWM compare uses (level*level) >> PWM_BITS for a perceptually
//                linear fade; full-on at LEVEL_MAX is kept.
//   undefined -> linear compare of level against the PWM counter; no multipliers.

module led_fade_driver #(
   parameter int WIDTH     = 18,
   parameter int PWM_BITS  = 8,
   parameter int STEP_DIV  = 50000,
   parameter int FADE_STEP = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_pattern,
   input  logic             bypass,
   output logic [WIDTH-1:0] led_out,
   output logic             busy
);

   localparam int TICK_BITS = $clog2(STEP_DIV);

   localparam logic [PWM_BITS-1:0]  LEVEL_MAX = '1;
   localparam logic [TICK_BITS-1:0] TICK_LAST = TICK_BITS'(STEP_DIV - 1);
   localparam logic [PWM_BITS:0]    STEP_EXT  = (PWM_BITS + 1)'(FADE_STEP);
   localparam logic [PWM_BITS:0]    MAX_EXT   = {1'b0, LEVEL_MAX};

   logic [WIDTH-1:0]     in_q;
   logic [PWM_BITS-1:0]  level     [WIDTH];
   logic [PWM_BITS-1:0]  level_nxt [WIDTH];
   logic [TICK_BITS-1:0] tick_cnt;
   logic [PWM_BITS-1:0]  pwm_cnt;
   logic                 tick;
   logic [WIDTH-1:0]     led_nxt;
   logic                 busy_nxt;

   // Saturating one-tick ramp; the extra bit on the way up keeps the sum from wrapping.
   function automatic logic [PWM_BITS-1:0] next_level(
      input logic [PWM_BITS-1:0] cur,
      input logic                up,
      input logic                byp,
      input logic                tck
   );
      logic [PWM_BITS:0] sum;
      sum        = {1'b0, cur} + STEP_EXT;
      next_level = cur;
      if (byp) begin
         next_level = up ? LEVEL_MAX : '0;
      end else if (tck && up) begin
         next_level = (sum > MAX_EXT) ? LEVEL_MAX : sum[PWM_BITS-1:0];
      end else if (tck) begin
         next_level = ({1'b0, cur} < STEP_EXT) ? '0 : (cur - STEP_EXT[PWM_BITS-1:0]);
      end
   endfunction

   // Pin drive for one channel; the equality term keeps LEVEL_MAX solidly on.
   function automatic logic pwm_on(
      input logic [PWM_BITS-1:0] cur,
      input logic [PWM_BITS-1:0] cnt
   );
`ifdef LED_FADE_GAMMA_EN
      logic [2*PWM_BITS-1:0] sq;
      sq     = {{PWM_BITS{1'b0}}, cur} * {{PWM_BITS{1'b0}}, cur};
      pwm_on = (cur == LEVEL_MAX) || (sq[2*PWM_BITS-1:PWM_BITS] > cnt);
`else
      pwm_on = (cur == LEVEL_MAX) || (cur > cnt);
`endif
   endfunction

   // Next levels, next pin drive and settle status for all channels.
   always_comb begin
      tick     = (tick_cnt == TICK_LAST);
      led_nxt  = '0;
      busy_nxt = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
         level_nxt[i] = next_level(level[i], in_q[i], bypass, tick);
         led_nxt[i]   = pwm_on(level[i], pwm_cnt);
         if (level[i] != {PWM_BITS{in_q[i]}}) begin
            busy_nxt = 1'b1;
         end
      end
   end

   // Input capture, free-running prescaler and PWM counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         in_q     <= '0;
         tick_cnt <= '0;
         pwm_cnt  <= '0;
      end else begin
         in_q     <= in_pattern;
         tick_cnt <= tick ? '0 : (tick_cnt + 1'b1);
         pwm_cnt  <= pwm_cnt + 1'b1;
      end
   end

   // Brightness levels; reset abandons any ramp in progress.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < WIDTH; i++) begin
            level[i] <= '0;
         end
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            level[i] <= level_nxt[i];
         end
      end
   end

   // Registered pin drive and busy flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         led_out <= '0;
         busy    <= 1'b0;
      end else begin
         led_out <= led_nxt;
         busy    <= busy_nxt;
      end
   end

endmodule

// File: tb/tb_led_fade_driver.sv
// Bench for led_fade_driver: cycle model + scoreboard for the main instance,
// plus two small instances for saturation (step 6) and duty measurement
// (slow prescaler, step 8).

module tb_led_fade_driver;

   localparam int W    = 18;
   localparam int PB   = 4;
   localparam int SD   = 4;
   localparam int FS   = 1;
   localparam int LMAX = 15;

   logic         clk = 1'b0;
   logic         reset;
   logic         bypass;
   logic [W-1:0] in_pattern;
   logic [W-1:0] led_out;
   logic         busy;

   logic         byp_aux;
   logic [W-1:0] pat6, patd;
   logic [W-1:0] led6, ledd;
   logic         busy6, busyd;

   led_fade_driver #(.WIDTH(W), .PWM_BITS(PB), .STEP_DIV(SD), .FADE_STEP(FS)) dut (
      .clk(clk), .reset(reset), .in_pattern(in_pattern), .bypass(bypass),
      .led_out(led_out), .busy(busy));

   led_fade_driver #(.WIDTH(W), .PWM_BITS(PB), .STEP_DIV(SD), .FADE_STEP(6)) dut6 (
      .clk(clk), .reset(reset), .in_pattern(pat6), .bypass(byp_aux),
      .led_out(led6), .busy(busy6));

   led_fade_driver #(.WIDTH(W), .PWM_BITS(PB), .STEP_DIV(64), .FADE_STEP(8)) dut_d (
      .clk(clk), .reset(reset), .in_pattern(patd), .bypass(byp_aux),
      .led_out(ledd), .busy(busyd));

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic check_val(input string tag, input int unsigned act, input int unsigned exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h @%0t", tag, act, exp, $time);
      end
   endtask

   typedef struct {
      logic [W-1:0] led;
      logic         busy;
   } exp_t;

   exp_t         sb_q[$];
   logic [W-1:0] m_inq;
   int           m_lvl[W];
   int           m_tick;
   int           m_pwm;
   bit           m_ticked;

   function automatic int cmp_val(input int l);
`ifdef LED_FADE_GAMMA_EN
      return (l * l) >> PB;
`else
      return l;
`endif
   endfunction

   // Predict what the coming rising edge produces, from the inputs now applied.
   task automatic model_step();
      exp_t e;
      int   nl[W];
      int   tgt;
      bit   tk;
      e.led  = '0;
      e.busy = 1'b0;
      if (reset) begin
         m_inq = '0;
         foreach (m_lvl[i]) m_lvl[i] = 0;
         m_tick   = 0;
         m_pwm    = 0;
         m_ticked = 0;
      end else begin
         tk = (m_tick == SD - 1);
         for (int i = 0; i < W; i++) begin
            tgt       = m_inq[i] ? LMAX : 0;
            e.led[i]  = (m_lvl[i] == LMAX) || (cmp_val(m_lvl[i]) > m_pwm);
            if (m_lvl[i] != tgt) e.busy = 1'b1;
            if (bypass)        nl[i] = tgt;
            else if (!tk)      nl[i] = m_lvl[i];
            else if (m_inq[i]) nl[i] = (m_lvl[i] + FS > LMAX) ? LMAX : m_lvl[i] + FS;
            else               nl[i] = (m_lvl[i] - FS < 0) ? 0 : m_lvl[i] - FS;
         end
         m_lvl    = nl;
         m_inq    = in_pattern;
         m_tick   = (m_tick + 1) % SD;
         m_pwm    = (m_pwm + 1) % (LMAX + 1);
         m_ticked = tk;
      end
      sb_q.push_back(e);
   endtask

   task automatic cycle();
      exp_t e;
      model_step();
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      check_val("sb_led", led_out, e.led);
      check_val("sb_busy", busy, e.busy);
   endtask

   task automatic wait_tick();
      bit ok;
      ok = 0;
      for (int n = 0; n < 2 * SD + 2 && !ok; n++) begin
         cycle();
         if (m_ticked) ok = 1;
      end
      check_val("tick_seen", ok, 1);
   endtask

   task automatic wait_lvl_d(input int target, input int budget);
      bit ok;
      ok = 0;
      for (int n = 0; n < budget && !ok; n++) begin
         cycle();
         if (dut_d.level[0] == target) ok = 1;
      end
      check_val("duty_lvl_reached", ok, 1);
   endtask

   task automatic count_d(output int hi);
      hi = 0;
      repeat (16) begin
         cycle();
         hi += int'(ledd[0]);
      end
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      cycle();
      reset = 1'b0;
   endtask

   initial begin
      int  hi;
      bit  seen;
      bit  hit7;
      int  exp_duty;

      reset      = 1'b1;
      bypass     = 1'b0;
      byp_aux    = 1'b0;
      in_pattern = '1;
      pat6       = '0;
      patd       = '0;

      // reset held two cycles with all inputs high
      cycle();
      check_val("rst_led_c1", led_out, 0);
      cycle();
      check_val("rst_led_c2", led_out, 0);
      check_val("rst_busy", busy, 0);
      reset = 1'b0;
      seen  = 0;
      repeat (3) begin
         cycle();
         if (busy) seen = 1;
      end
      check_val("rst_busy_rise", seen, 1);

      // fade-in of bit 0
      in_pattern = 18'h00001;
      pulse_reset();
      for (int k = 1; k <= LMAX; k++) begin
         wait_tick();
         check_val("fade_lvl", dut.level[0], k);
      end
      cycle();
      check_val("fade_busy_low", busy, 0);
      count_d(hi);
      hi = 0;
      repeat (16) begin
         cycle();
         hi += int'(led_out[0]);
      end
      check_val("fade_full_on", hi, 16);
      check_val("fade_others_off", led_out[W-1:1], 0);

      // duty at level 8, then full-on, then zero
`ifdef LED_FADE_GAMMA_EN
      exp_duty = 4;
`else
      exp_duty = 8;
`endif
      patd = 18'h00001;
      pulse_reset();
      wait_lvl_d(8, 100);
      cycle();
      cycle();
      count_d(hi);
      check_val("duty_l8", hi, exp_duty);
      wait_lvl_d(15, 80);
      cycle();
      cycle();
      count_d(hi);
      check_val("duty_l15", hi, 16);
      patd = '0;
      wait_lvl_d(0, 160);
      cycle();
      cycle();
      count_d(hi);
      check_val("duty_l0", hi, 0);

      // saturation and floor with step 6
      pat6 = 18'h00001;
      pulse_reset();
      check_val("sat_l0", dut6.level[0], 0);
      wait_tick(); check_val("sat_up1", dut6.level[0], 6);
      wait_tick(); check_val("sat_up2", dut6.level[0], 12);
      wait_tick(); check_val("sat_up3", dut6.level[0], 15);
      wait_tick(); check_val("sat_up4", dut6.level[0], 15);
      pat6 = '0;
      wait_tick(); check_val("sat_dn1", dut6.level[0], 9);
      wait_tick(); check_val("sat_dn2", dut6.level[0], 3);
      wait_tick(); check_val("sat_dn3", dut6.level[0], 0);
      wait_tick(); check_val("sat_dn4", dut6.level[0], 0);

      // bypass: three-edge latency, steady output, clean exit
      bypass     = 1'b1;
      in_pattern = '0;
      repeat (4) cycle();
      in_pattern = 18'h2A5A5;
      cycle();
      cycle();
      check_val("byp_edge2", led_out, 0);
      cycle();
      check_val("byp_edge3", led_out, 18'h2A5A5);
      repeat (5) cycle();
      check_val("byp_steady", led_out, 18'h2A5A5);
      in_pattern = '0;
      cycle();
      cycle();
      check_val("byp_clr_edge2", led_out, 18'h2A5A5);
      cycle();
      check_val("byp_clr_edge3", led_out, 0);
      bypass = 1'b0;
      repeat (8) cycle();
      check_val("byp_exit_lvl", dut.level[1], 0);

      // reversal mid-ramp, then reset mid-fade
      in_pattern = 18'h00020;
      hit7 = 0;
      for (int n = 0; n < 12 && !hit7; n++) begin
         wait_tick();
         if (dut.level[5] == 7) hit7 = 1;
      end
      check_val("rev_reach7", hit7, 1);
      in_pattern = '0;
      wait_tick(); check_val("rev_lvl6", dut.level[5], 6);
      wait_tick(); check_val("rev_lvl5", dut.level[5], 5);
      reset = 1'b1;
      cycle();
      check_val("rev_rst_lvl", dut.level[5], 0);
      check_val("rev_rst_led", led_out, 0);
      check_val("rev_rst_busy", busy, 0);
      reset = 1'b0;
      repeat (4) cycle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
